// File: rtl/fnd_sum_display.sv
// fnd_sum_display: binary-to-BCD shift-add-3 converter driving a scanned 4-digit common-anode FND
module fnd_sum_display #(
  parameter int P_DATA_W = 5,
  parameter int P_SCAN_DIV = 100000,
  parameter bit P_BLANK_LEADING = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [P_DATA_W-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [3:0]          o_fnd_com,
  output logic [7:0]          o_fnd_font
);
  localparam int CW = $clog2(P_DATA_W + 1);
  localparam int PW = $clog2(P_SCAN_DIV);
  typedef enum logic [1:0] {IDLE, ADJ, SHIFT, UPDATE} state_t;
  state_t state;
  logic [P_DATA_W-1:0] bin;
  logic [15:0] scr, disp, sh;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pre;
  logic [1:0] idx;
  logic wrap, blank;
  function automatic logic [15:0] adj3(input logic [15:0] s);
    for (int n = 0; n < 4; n++)
      adj3[4*n +: 4] = s[4*n +: 4] >= 4'd5 ? s[4*n +: 4] + 4'd3 : s[4*n +: 4];
  endfunction
  function automatic logic [7:0] font(input logic [3:0] d);
    case (d)
      4'd0: font = 8'hC0;
      4'd1: font = 8'hF9;
      4'd2: font = 8'hA4;
      4'd3: font = 8'hB0;
      4'd4: font = 8'h99;
      4'd5: font = 8'h92;
      4'd6: font = 8'h82;
      4'd7: font = 8'hF8;
      4'd8: font = 8'h80;
      4'd9: font = 8'h90;
      default: font = 8'hFF;
    endcase
  endfunction
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      o_ready <= 1'b1;
      bin <= '0;
      scr <= '0;
      cnt <= '0;
      disp <= '0;
    end else
      case (state)
        IDLE:
          if (i_valid) begin
            bin <= i_data;
            scr <= '0;
            cnt <= CW'(P_DATA_W);
            o_ready <= 1'b0;
            state <= ADJ;
          end
        ADJ: begin
          scr <= adj3(scr);
          state <= SHIFT;
        end
        SHIFT: begin
          scr <= {scr[14:0], bin[P_DATA_W-1]};
          bin <= bin << 1;
          cnt <= cnt - 1'b1;
          state <= cnt == CW'(1) ? UPDATE : ADJ;
        end
        default: begin
          disp <= scr;
          o_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
  assign sh = disp >> {idx, 2'b00};
  assign wrap = pre == PW'(P_SCAN_DIV - 1);
  // higher digits all zero => sh (this digit and above) is zero
  assign blank = P_BLANK_LEADING && idx != 2'd0 && sh == 16'd0;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      pre <= '0;
      idx <= '0;
      o_fnd_com <= 4'hF;
      o_fnd_font <= 8'hFF;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      idx <= wrap ? idx + 1'b1 : idx;
      o_fnd_com <= ~(4'b0001 << idx);
      o_fnd_font <= blank ? 8'hFF : font(sh[3:0]);
    end
endmodule

// File: doc/fnd_sum_display.md
Name: fnd_sum_display

Overview:
Consumes the binary result of the 4-bit ripple adder (sum plus carry-out) and drives the 4-digit common-anode FND. Each accepted value is converted to BCD with a sequential shift-add-3 FSM. All four digits are time-multiplexed by a scan counter. The block sits between the adder datapath and the board FND pins.

Parameters:
P_DATA_W, 5, width of input binary value; legal range 1..13 so the result fits 4 decimal digits.
P_SCAN_DIV, 100000, clock cycles each digit stays enabled; must be ≥ 2.
P_BLANK_LEADING, 1, 1 = blank leading-zero digits; 0 = show all four digits.

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_data  input  P_DATA_W  binary value to display, e.g. {carry, sum[3:0]}
i_valid  input  1  i_data is valid; accepted only when o_ready=1
o_ready  output  1  1 = converter idle and accepting
o_fnd_com  output  4  digit enables, active-low; bit0 = ones digit
o_fnd_font  output  8  segments {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - FSM = IDLE, o_ready=1.
  - Display register = 0, scan prescaler = 0, digit index = 0.
  - o_fnd_com = 4'b1111, o_fnd_font = 8'hFF.
- Converter FSM states:
  - IDLE: o_ready=1. On i_valid=1 at a clock edge, capture i_data, clear BCD scratch, load bit counter = P_DATA_W, go to ADJ.
  - ADJ: for each scratch BCD nibble ≥ 5, add 3. Go to SHIFT.
  - SHIFT: shift {scratch, binary} left by 1 and decrement the counter. If counter = 0, go to UPDATE; otherwise go to ADJ.
  - UPDATE: copy scratch to the display register, go to IDLE.
- o_ready=0 in every state except IDLE.
- i_valid while o_ready=0 is ignored. It is not queued.
- Latency: accept at edge k; display register holds the new value after edge k+2·P_DATA_W+1. o_ready returns to 1 at that same edge. Next accept is possible at edge k+2·P_DATA_W+2.
- The display keeps showing the previous value for the whole conversion.
- Scan:
  - Prescaler counts 0..P_SCAN_DIV-1 and wraps.
  - On the wrap edge, digit index increments 0→1→2→3→0.
- Outputs are registered and update every clock from the digit index and display register:
  - o_fnd_com = ~(4'b0001 << index).
  - o_fnd_font = font(digit[index]).
  - First non-reset output appears at the first edge after reset release: com 4'b1110.
- Font, active-low, dp always off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
- Blanking (P_BLANK_LEADING=1):
  - Digit n>0 shows font FF when digits n..3 are all zero. o_fnd_com for that digit is still driven low.
  - Digit 0 is never blanked, so value 0 shows "0".
- Reset asserted mid-conversion aborts it. The captured value is discarded, and the display returns to 0 after release.
- P_DATA_W>13 is an illegal configuration. Behaviour is unspecified.

Test Plan:
1. Reset released, P_SCAN_DIV=4, no input:
   - com sequence 1110, 1101, 1011, 0111, repeating; each held 4 cycles.
   - font C0 during 1110, FF on all other digits.
2. Load i_data=5'd31 (15+15+1) at edge k:
   - o_ready=0 from edge k through edge k+10, =1 after edge k+11.
   - Display after edge k+11: digit0 font F9, digit1 B0, digits 2/3 FF.
3. Load 5'd31, then 5'd0:
   - digit0 C0, digits 1–3 FF.
   - With P_BLANK_LEADING=0: all four digits C0.
4. Load 5'd12, then hold i_valid=1 with i_data=5'd7 through the conversion:
   - First conversion shows digit1 F9, digit0 A4.
   - 7 is accepted only at the first edge after o_ready returns to 1.
5. Assert i_reset 4 cycles into a 5'd25 conversion:
   - Outputs go to com 1111 / font FF immediately, o_ready=1.
   - After release, display shows 0 (digit0 C0).
6. P_DATA_W=13, load 8191:
   - o_ready low for 27 cycles.
   - digit3 80, digit2 F9, digit1 90, digit0 F9.
